// File: rtl/sram_bit_array_arb_ctrl.sv
// rtl/sram_bit_array_arb_ctrl.sv - two-port round-robin arbiter and sequencer for a single-bit SRAM cell array
module sram_bit_array_arb_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic             wdata0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic             wdata1,
  output logic             gnt1,
  output logic             done,
  output logic             done_id,
  output logic             rdata,
  output logic             err,
  output logic [DEPTH-1:0] cell_wl,
  output logic [DEPTH-1:0] cell_wb,
  output logic             cell_write_en,
  output logic             cell_blb,
  output logic             cell_data_in,
  input  logic             cell_data_out
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic             id_q, we_q, wdata_q, err_q, last_q;
  logic [AW-1:0]    addr_q;
  logic             grant_any, grant_id;
  logic             addr_oor;
  logic [DEPTH-1:0] sel;

  assign addr_oor = (32'(addr_q) >= 32'(DEPTH));

  // Arbitration: single requester wins outright, a tie goes to the port not granted last
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE && reset_n) begin
      if (req0 && req1) begin
        grant_any = 1'b1;
        grant_id  = ~last_q;
      end else if (req0) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // Next-state sequencing: IDLE waits for a grant, the other states last one cycle each
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, request latch, range flag, round-robin pointer and read data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_any) begin
        id_q    <= grant_id;
        last_q  <= grant_id;
        we_q    <= grant_id ? we1    : we0;
        addr_q  <= grant_id ? addr1  : addr0;
        wdata_q <= grant_id ? wdata1 : wdata0;
      end
      if (state_q == SETUP) err_q <= addr_oor;
      if (state_q == ACCESS && !we_q) rdata <= err_q ? 1'b0 : cell_data_out;
    end
  end

  // One-hot cell select from the latched address
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_q == AW'(i)) sel[i] = 1'b1;
    end
  end

  // Grant pulses, cell strobes and response outputs decoded from the current state
  always_comb begin
    gnt0          = grant_any & ~grant_id;
    gnt1          = grant_any & grant_id;
    done          = 1'b0;
    done_id       = 1'b0;
    err           = 1'b0;
    cell_wl       = '0;
    cell_wb       = '0;
    cell_write_en = 1'b0;
    cell_blb      = 1'b1;
    cell_data_in  = 1'b0;
    case (state_q)
      SETUP: begin
        cell_data_in = wdata_q;
      end
      ACCESS: begin
        cell_data_in = wdata_q;
        if (!err_q) begin
          if (we_q) begin
            cell_write_en = 1'b1;
            cell_wb       = sel;
          end else begin
            cell_wl  = sel;
            cell_blb = 1'b0;
          end
        end
      end
      RESP: begin
        done    = 1'b1;
        done_id = id_q;
        err     = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_bit_array_arb_ctrl.sv
// tb/tb_sram_bit_array_arb_ctrl.sv - scoreboard bench for sram_bit_array_arb_ctrl with a behavioural cell array
module tb_sram_bit_array_arb_ctrl;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req0 = 1'b0, we0 = 1'b0, wdata0 = 1'b0;
  logic             req1 = 1'b0, we1 = 1'b0, wdata1 = 1'b0;
  logic [AW-1:0]    addr0 = '0, addr1 = '0;
  logic             gnt0, gnt1, done, done_id, rdata, err;
  logic [DEPTH-1:0] cell_wl, cell_wb;
  logic             cell_write_en, cell_blb, cell_data_in;
  logic             cell_data_out;

  sram_bit_array_arb_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
    .done(done), .done_id(done_id), .rdata(rdata), .err(err),
    .cell_wl(cell_wl), .cell_wb(cell_wb), .cell_write_en(cell_write_en),
    .cell_blb(cell_blb), .cell_data_in(cell_data_in), .cell_data_out(cell_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic id;
    logic err;
    logic rdata;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   ref_mem [DEPTH];
  bit   phys    [DEPTH];
  logic last_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Cell array: write on the edge when write-enable and a write bit are up; drive data when read-selected
  always @(posedge clk) begin
    if (cell_write_en)
      for (int i = 0; i < DEPTH; i++)
        if (cell_wb[i]) phys[i] <= cell_data_in;
  end

  always_comb begin
    cell_data_out = 1'b0;
    if (!cell_blb)
      for (int i = 0; i < DEPTH; i++)
        if (cell_wl[i]) cell_data_out = phys[i];
  end

  // Strobe-legality checks every cycle while out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      check("wl_onehot", 32'($countones(cell_wl) <= 1), 32'd1);
      check("wb_onehot", 32'($countones(cell_wb) <= 1), 32'd1);
      check("wl_wb_excl", 32'((|cell_wl) && (|cell_wb)), 32'd0);
      check("we_needs_wb", 32'(cell_write_en && !(|cell_wb)), 32'd0);
      check("blb_needs_wl", 32'(!cell_blb && !(|cell_wl)), 32'd0);
    end
  end

  task automatic set_port(input bit p, input bit r, input bit w, input logic [AW-1:0] a, input bit d);
    if (p == 1'b0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic txn(input bit p, input bit w, input logic [AW-1:0] a, input bit d,
                     input logic [AW-1:0] a_after, input bit hold_other);
    exp_t             e;
    bit               got;
    bit               oor;
    logic [DEPTH-1:0] one;
    logic [DEPTH-1:0] hot;
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    if (hold_other) set_port(~p, 1'b1, 1'b0, '0, 1'b0);
    #1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (p ? gnt1 : gnt0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (!got) begin
      set_port(p, 1'b0, 1'b0, '0, 1'b0);
      set_port(~p, 1'b0, 1'b0, '0, 1'b0);
      return;
    end
    check("gnt_other", 32'(p ? gnt0 : gnt1), 32'd0);
    oor   = (32'(a) >= 32'(DEPTH));
    e.id  = p;
    e.err = oor;
    if (w) begin
      if (!oor) ref_mem[a] = d;
      e.rdata = last_rd;
    end else begin
      e.rdata = oor ? 1'b0 : ref_mem[a];
      last_rd = e.rdata;
    end
    sb.push_back(e);
    one = 1;
    hot = one << a;
    @(posedge clk);
    #1;
    set_port(p, 1'b0, ~w, a_after, ~d);
    got = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check("acc_wb", 32'(cell_wb), (w && !oor) ? 32'(hot) : 32'd0);
        check("acc_wl", 32'(cell_wl), (!w && !oor) ? 32'(hot) : 32'd0);
        check("acc_we", 32'(cell_write_en), 32'(w && !oor));
        check("acc_blb", 32'(cell_blb), 32'(!(!w && !oor)));
        if (w) check("acc_din", 32'(cell_data_in), 32'(d));
      end
      if (done) begin
        check("done_lat", 32'(k), 32'd3);
        got = 1'b1;
        break;
      end
    end
    if (hold_other) set_port(~p, 1'b0, 1'b0, '0, 1'b0);
    check("done_seen", 32'(got), 32'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check("done_id", 32'(done_id), 32'(e.id));
      check("err", 32'(err), 32'(e.err));
      check("rdata", 32'(rdata), 32'(e.rdata));
    end
  endtask

  initial begin
    exp_t e;
    bit   got;
    int   prev_cyc;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_done", 32'({done, done_id, err, rdata}), 32'd0);
    check("rst_strobes", 32'({cell_wl, cell_wb}), 32'd0);
    check("rst_we_din", 32'({cell_write_en, cell_data_in}), 32'd0);
    check("rst_blb", 32'(cell_blb), 32'd1);
    reset_n = 1'b1;
    last_rd = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1 every 4 cycles
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    set_port(1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
    #1;
    prev_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) begin
        @(negedge clk);
        #1;
      end
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
        if (gnt0 || gnt1) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
      check("cont_gnt_seen", 32'(got), 32'd1);
      check("cont_gnt_order", 32'({gnt0, gnt1}), (g % 2 == 0) ? 32'd2 : 32'd1);
      if (g > 0) check("cont_interval", 32'(cyc - prev_cyc), 32'd4);
      prev_cyc = cyc;
      e.id = g[0]; e.err = 1'b0; e.rdata = 1'b0;
      last_rd = 1'b0;
      sb.push_back(e);
      got = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        #1;
        if (done) begin
          check("cont_done_lat", 32'(k), 32'd3);
          got = 1'b1;
          break;
        end
      end
      check("cont_done_seen", 32'(got), 32'd1);
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        check("cont_done_id", 32'(done_id), 32'(e.id));
        check("cont_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
    set_port(1'b0, 1'b0, 1'b0, '0, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Port 0 write then read of cell 5
    txn(1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0);
    txn(1'b0, 1'b0, 4'd5, 1'b0, 4'd5, 1'b0);

    // Out-of-range read from port 1
    txn(1'b1, 1'b0, 4'd13, 1'b0, 4'd13, 1'b0);

    // Address changes after grant: cell 7 is still the one written
    txn(1'b1, 1'b1, 4'd7, 1'b1, 4'd2, 1'b0);
    txn(1'b1, 1'b0, 4'd7, 1'b0, 4'd7, 1'b0);
    txn(1'b0, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0);

    // Reset asserted during the ACCESS cycle of a write to cell 3
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 4'd3, ~ref_mem[3]);
    #1;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (gnt0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("rstw_gnt", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    set_port(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstw_pre_wb", 32'(cell_wb), 32'h8);
    reset_n = 1'b0;
    #1;
    check("rstw_wb", 32'(cell_wb), 32'd0);
    check("rstw_wl", 32'(cell_wl), 32'd0);
    check("rstw_we", 32'(cell_write_en), 32'd0);
    check("rstw_blb", 32'(cell_blb), 32'd1);
    check("rstw_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstw_no_done", 32'(done), 32'd0);
    end
    check("rstw_no_write", 32'(phys[3]), 32'(ref_mem[3]));
    reset_n = 1'b1;
    last_rd = 1'b0;
    txn(1'b0, 1'b0, 4'd3, 1'b0, 4'd3, 1'b1);

    // Random single-port traffic against the cell model
    for (int t = 0; t < 500; t++) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 1'b0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
